// File: rtl/i2c_target_pkg.sv
// Shared state encoding, register map constants and register read mux for the I2C target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_CONFIG   = 8'h03;
  localparam logic [7:0] REG_ID       = 8'h0B;

  function automatic logic [7:0] regRead(input logic [7:0]  ptr,
                                         input logic [15:0] snap,
                                         input logic [7:0]  cfg,
                                         input logic [7:0]  id);
    case (ptr)
      REG_TEMP_MSB: return snap[15:8];
      REG_TEMP_LSB: return snap[7:0];
      REG_CONFIG:   return cfg;
      REG_ID:       return id;
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// 2-FF synchronizer for one I2C line, idling high; an optional 3-sample glitch
// filter is enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_line_filter (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_line
);

  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], i_line};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_level;

  // A new level is accepted only once three consecutive samples agree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist  <= 2'b11;
      r_level <= 1'b1;
    end else begin
      r_hist <= {r_hist[0], r_sync[1]};
      if ({r_hist, r_sync[1]} == 3'b000)      r_level <= 1'b0;
      else if ({r_hist, r_sync[1]} == 3'b111) r_level <= 1'b1;
    end
  end

  assign o_line = r_level;
`else
  assign o_line = r_sync[1];
`endif

endmodule

// File: rtl/i2c_target_adt.sv
// I2C target with temperature snapshot, config and ID registers behind an auto-incrementing pointer.
// Build option: I2C_TARGET_GLITCH_FILTER_EN adds a glitch filter on SCL/SDA.
module i2c_target_adt
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR  = 7'h4B,
  parameter logic [7:0] DEVICE_ID = 8'hCB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_in,
  output logic [7:0]  config_out,
  output logic        cfg_wr,
  output logic        busy
);

  logic w_scl, w_sda;

  i2c_line_filter u_scl_filter (.clk(clk), .rst(rst), .i_line(scl_i), .o_line(w_scl));
  i2c_line_filter u_sda_filter (.clk(clk), .rst(rst), .i_line(sda_i), .o_line(w_sda));

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift, r_ptr, r_cfg;
  logic [15:0] r_snap;
  logic        r_scl_d, r_sda_d, r_sda_oe, r_busy, r_cfg_pend, r_cfg_wr, r_ack_phase, r_rw;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
  logic [7:0] w_byte, w_rd_byte;

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_rd_byte  = regRead(r_ptr, r_snap, r_cfg, DEVICE_ID);

  // ACK states use r_ack_phase: the first SCL fall drives/releases, the second ends the 9th clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_ptr       <= 8'h00;
      r_cfg       <= 8'h00;
      r_snap      <= 16'h0000;
      r_scl_d     <= 1'b1;
      r_sda_d     <= 1'b1;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_pend  <= 1'b0;
      r_cfg_wr    <= 1'b0;
      r_ack_phase <= 1'b0;
      r_rw        <= 1'b0;
    end else begin
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_cfg_pend <= 1'b0;
      r_cfg_wr   <= r_cfg_pend;
      if (w_start) begin
        r_state     <= ST_ADDR;
        r_bit_cnt   <= 3'd0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
        r_ack_phase <= 1'b0;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_ack_phase <= 1'b0;
                if (r_state == ST_ADDR) begin
                  r_rw    <= w_byte[0];
                  r_state <= (w_byte[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                end else if (r_state == ST_PTR) begin
                  r_ptr   <= w_byte;
                  r_state <= ST_PTR_ACK;
                end else begin
                  r_state <= ST_WDATA_ACK;
                  if (r_ptr == REG_CONFIG) begin
                    r_cfg      <= w_byte;
                    r_cfg_pend <= 1'b1;
                  end
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= 1'b1;
                r_ack_phase <= 1'b1;
                r_busy      <= 1'b1;
                if (r_rw) r_snap <= temp_in;
              end else begin
                r_ack_phase <= 1'b0;
                if (r_rw) begin
                  r_state  <= ST_RDATA;
                  r_shift  <= w_rd_byte;
                  r_sda_oe <= ~w_rd_byte[7];
                end else begin
                  r_state  <= ST_PTR;
                  r_sda_oe <= 1'b0;
                end
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= 1'b1;
                r_ack_phase <= 1'b1;
              end else begin
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
                r_state     <= ST_WDATA;
                if (r_state == ST_WDATA_ACK) r_ptr <= r_ptr + 8'd1;
              end
            end
          end
          ST_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_state     <= ST_RACK;
                r_ptr       <= r_ptr + 8'd1;
                r_ack_phase <= 1'b0;
              end
            end else if (w_scl_fall) begin
              r_sda_oe <= ~r_shift[3'd7 - r_bit_cnt];
            end
          end
          ST_RACK: begin
            if (w_scl_fall && !r_ack_phase) begin
              r_sda_oe <= 1'b0;
            end else if (w_scl_rise && !r_ack_phase) begin
              if (w_sda) begin
                r_state <= ST_IGNORE;
                r_busy  <= 1'b0;
              end else begin
                r_ack_phase <= 1'b1;
              end
            end else if (w_scl_fall && r_ack_phase) begin
              r_ack_phase <= 1'b0;
              r_state     <= ST_RDATA;
              r_shift     <= w_rd_byte;
              r_sda_oe    <= ~w_rd_byte[7];
            end
          end
          ST_IGNORE: r_sda_oe <= 1'b0;
          ST_IDLE:   r_sda_oe <= 1'b0;
          default:   r_state  <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign config_out = r_cfg;
  assign cfg_wr     = r_cfg_wr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_target_adt.sv
// Scoreboard bench for i2c_target_adt: a bus-level master drives transactions and a queue-based monitor checks responses.
module tb_i2c_target_adt;
  import i2c_target_pkg::*;

  localparam int Q = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] temp_in = 16'h0000;
  logic        sda_bus;
  logic        sda_oe;
  logic [7:0]  config_out;
  logic        cfg_wr;
  logic        busy;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_adt dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .temp_in(temp_in), .config_out(config_out), .cfg_wr(cfg_wr), .busy(busy)
  );

  typedef struct {
    string name;
    int    val;
  } item_t;

  item_t expQ[$], obsQ[$], cExpQ[$], cObsQ[$];
  int total = 0;
  int bad = 0;

  logic [7:0]  mCfg = 8'h00;
  logic [7:0]  mPtr = 8'h00;
  logic [15:0] mSnap = 16'h0000;

  function automatic void checkOutput(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic item_t mk(string n, int v);
    item_t t;
    t.name = n;
    t.val  = v;
    return t;
  endfunction

  function automatic void expect_(string n, int v);
    expQ.push_back(mk(n, v));
  endfunction

  function automatic void observe(string n, int v);
    obsQ.push_back(mk(n, v));
  endfunction

  function automatic void expectCfg(logic [7:0] v);
    cExpQ.push_back(mk("cfgVal", int'(v)));
    cExpQ.push_back(mk("cfgPrev", int'(v)));
    cExpQ.push_back(mk("cfgLen", 1));
  endfunction

  // Register map as seen by the master: snapshot bytes, config, ID, zeros elsewhere.
  function automatic logic [7:0] modelRead(input logic [7:0] a);
    case (a)
      8'h00:   return mSnap[15:8];
      8'h01:   return mSnap[7:0];
      8'h03:   return mCfg;
      8'h0B:   return 8'hCB;
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: pairs each observed response with the oldest expectation.
  initial begin
    item_t o, e;
    forever begin
      @(posedge clk);
      while (obsQ.size() > 0) begin
        o = obsQ.pop_front();
        if (expQ.size() == 0) checkOutput({"unexpected ", o.name}, o.val, -1);
        else begin
          e = expQ.pop_front();
          checkOutput((o.name == e.name) ? e.name : {e.name, "/", o.name}, o.val,
                      (o.name == e.name) ? e.val : -1);
        end
      end
      while (cObsQ.size() > 0) begin
        o = cObsQ.pop_front();
        if (cExpQ.size() == 0) checkOutput({"unexpected ", o.name}, o.val, -1);
        else begin
          e = cExpQ.pop_front();
          checkOutput((o.name == e.name) ? e.name : {e.name, "/", o.name}, o.val,
                      (o.name == e.name) ? e.val : -1);
        end
      end
    end
  end

  // cfg_wr watcher: value at the pulse, value one cycle earlier, and pulse length.
  initial begin
    logic       prevWr;
    logic [7:0] prevCfg;
    int         len;
    prevWr = 1'b0;
    prevCfg = 8'h00;
    len = 0;
    forever begin
      @(negedge clk);
      if (cfg_wr && !prevWr) begin
        cObsQ.push_back(mk("cfgVal", int'(config_out)));
        cObsQ.push_back(mk("cfgPrev", int'(prevCfg)));
      end
      if (cfg_wr) len++;
      else if (prevWr) begin
        cObsQ.push_back(mk("cfgLen", len));
        len = 0;
      end
      prevWr  = cfg_wr;
      prevCfg = config_out;
    end
  end

  task automatic writeBit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic readBit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic startCond();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic stopCond();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(b[i]);
    readBit(ack);
  endtask

  task automatic recvByte(output logic [7:0] b, input logic nack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      readBit(bit_v);
      b[i] = bit_v;
    end
    writeBit(nack);
  endtask

  task automatic checkBusyAfterStop();
    #Q;
    expect_("busyAfterStop", 0);
    observe("busyAfterStop", int'(busy));
  endtask

  // Write transaction: first byte is the pointer, further bytes are data.
  task automatic writeTxn(input logic [6:0] addr, input int n, input logic [31:0] bytes, input logic doStop);
    logic       ack;
    logic [7:0] b;
    logic       match;
    match = (addr == 7'h4B);
    startCond();
    expect_("addrAck", match ? 0 : 1);
    sendByte({addr, 1'b0}, ack);
    observe("addrAck", int'(ack));
    if (!match) begin
      expect_("stIgnore", int'(ST_IGNORE));
      observe("stIgnore", int'(dut.r_state));
    end
    for (int i = 0; i < n; i++) begin
      b = bytes[8*i +: 8];
      if (match) begin
        if (i == 0) mPtr = b;
        else begin
          if (mPtr == 8'h03) begin
            mCfg = b;
            expectCfg(b);
          end
          mPtr = mPtr + 8'd1;
        end
      end
      expect_(match ? "dataAck" : "ignAck", match ? 0 : 1);
      sendByte(b, ack);
      observe(match ? "dataAck" : "ignAck", int'(ack));
    end
    if (doStop) begin
      stopCond();
      checkBusyAfterStop();
    end
  endtask

  // Read transaction from the current pointer; the last byte is NACKed.
  task automatic readTxn(input int n, input logic chg, input logic [15:0] newT);
    logic       ack;
    logic [7:0] b;
    logic [7:0] e;
    startCond();
    mSnap = temp_in;
    expect_("addrAckRd", 0);
    sendByte({7'h4B, 1'b1}, ack);
    observe("addrAckRd", int'(ack));
    expect_("busyActive", 1);
    observe("busyActive", int'(busy));
    for (int i = 0; i < n; i++) begin
      e = modelRead(mPtr);
      mPtr = mPtr + 8'd1;
      expect_("rdByte", int'(e));
      recvByte(b, i == n - 1);
      observe("rdByte", int'(b));
      if (chg && i == 0) temp_in = newT;
    end
    expect_("oeAfterNack", 0);
    observe("oeAfterNack", int'(sda_oe));
    stopCond();
    checkBusyAfterStop();
  endtask

  function automatic logic [7:0] pickPtr();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h01;
      2, 3:    return 8'h03;
      4:       return 8'h0B;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic applyStimulus();
    logic [31:0] d;
    logic [7:0]  p;
    int          n;
    temp_in = 16'($urandom);
    d = $urandom;
    p = pickPtr();
    case ($urandom_range(0, 2))
      0: begin
        n = int'($urandom_range(1, 3));
        writeTxn(7'h4B, n + 1, {d[23:0], p}, 1'b1);
      end
      1: begin
        writeTxn(7'h4B, 1, {24'h0, p}, 1'b0);
        readTxn(int'($urandom_range(1, 3)), 1'b0, 16'h0);
      end
      default: readTxn(int'($urandom_range(1, 2)), 1'b0, 16'h0);
    endcase
  endtask

  initial begin
    logic       ack;
    logic [7:0] addrW;
    item_t      e;

    #1;
    expect_("oeRst", 0);     observe("oeRst", int'(sda_oe));
    expect_("busyRst", 0);   observe("busyRst", int'(busy));
    expect_("cfgWrRst", 0);  observe("cfgWrRst", int'(cfg_wr));
    expect_("cfgRst", 0);    observe("cfgRst", int'(config_out));
    expect_("stRst", int'(ST_IDLE)); observe("stRst", int'(dut.r_state));
    #50;
    rst = 1'b1;
    #(2*Q);

    // ID read through a repeated start
    writeTxn(7'h4B, 1, 32'h0000_000B, 1'b0);
    readTxn(1, 1'b0, 16'h0);

    // config write
    writeTxn(7'h4B, 2, 32'h0000_8303, 1'b1);
    expect_("cfgOut", int'(mCfg)); observe("cfgOut", int'(config_out));

    // snapshot coherence
    temp_in = 16'h0C80;
    writeTxn(7'h4B, 1, 32'h0000_0000, 1'b0);
    readTxn(2, 1'b1, 16'h1000);

    // wrong address is ignored
    writeTxn(7'h4A, 2, 32'h0000_5503, 1'b1);
    expect_("cfgKept", int'(mCfg)); observe("cfgKept", int'(config_out));

    // pointer wrap
    temp_in = 16'hA5C3;
    writeTxn(7'h4B, 1, 32'h0000_00FF, 1'b0);
    readTxn(2, 1'b0, 16'h0);

    for (int k = 0; k < 12; k++) applyStimulus();

    // reset while the target drives the address ACK
    writeTxn(7'h4B, 2, 32'h0000_5A03, 1'b1);
    startCond();
    addrW = 8'h96;
    for (int i = 7; i >= 0; i--) writeBit(addrW[i]);
    expect_("ackDriven", 1); observe("ackDriven", int'(sda_oe));
    rst = 1'b0;
    #1;
    expect_("oeInRst", 0);   observe("oeInRst", int'(sda_oe));
    expect_("cfgInRst", 0);  observe("cfgInRst", int'(config_out));
    expect_("busyInRst", 0); observe("busyInRst", int'(busy));
    mCfg = 8'h00;
    mPtr = 8'h00;
    mSnap = 16'h0000;
    sda_m = 1'b1;
    #Q;
    rst = 1'b1;
    #Q;
    expect_("idleAck", 1);
    sendByte(addrW, ack);
    observe("idleAck", int'(ack));
    expect_("stIdle", int'(ST_IDLE)); observe("stIdle", int'(dut.r_state));
    stopCond();
    #Q;
    temp_in = 16'h3C5A;
    readTxn(2, 1'b0, 16'h0);

    #(10*Q);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL %s: no response seen, expected 0x%0h", e.name, e.val);
    end
    while (cExpQ.size() > 0) begin
      e = cExpQ.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL %s: no cfg_wr response seen, expected 0x%0h", e.name, e.val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
